// File: rtl/univ_shift_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : univ_shift_reg_if
// Description : Control and status bundle for univ_shift_reg.
//               master : drives load/shift/burst controls, observes status
//               slave  : the shift register itself
//               Signals: load_en, d_load[WIDTH], shift_en, start,
//                        count[CNT_W], dir, mode, sin  (master -> slave)
//                        q[WIDTH], sout, busy, done     (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface univ_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             load_en;
    logic [WIDTH-1:0] d_load;
    logic             shift_en;
    logic             start;
    logic [CNT_W-1:0] count;
    logic             dir;
    logic             mode;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output load_en, d_load, shift_en, start, count, dir, mode, sin,
        input  q, sout, busy, done
    );

    modport slave (
        input  load_en, d_load, shift_en, start, count, dir, mode, sin,
        output q, sout, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : univ_shift_reg
// Description : Parametrised universal shift register with parallel load,
//               left/right shift or rotate, serial in/out and a counted
//               burst-shift controller (IDLE -> SHIFT -> DONE).
//               Ports: clk, rst (sync, active-high)
//                      bus (univ_shift_reg_if.slave) - controls and status
// Revision    : 1.0 - initial release
// ============================================================================
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    univ_shift_reg_if.slave    bus
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic             r_mode;
    logic [WIDTH-1:0] r_q;
    logic             r_sout;

    logic             w_step_dir;
    logic             w_step_mode;
    logic             w_out_bit;
    logic             w_fill;
    logic [WIDTH-1:0] w_shifted;
    logic             w_do_step;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; a parallel load aborts any burst silently.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (bus.load_en) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        w_state_nxt = (bus.count != '0) ? c_ST_SHIFT : c_ST_DONE;
                    end
                end
                c_ST_SHIFT: begin
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    w_state_nxt = c_ST_IDLE;
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode from registered state
    // ------------------------------------------------------------------
    always_comb begin
        bus.busy = (r_state == c_ST_SHIFT);
        bus.done = (r_state == c_ST_DONE);
    end

    // ------------------------------------------------------------------
    // Shift datapath. Bursts use the direction/mode captured at start so
    // the controls may change underneath; idle single steps use live ones.
    // ------------------------------------------------------------------
    always_comb begin
        w_step_dir  = (r_state == c_ST_SHIFT) ? r_dir  : bus.dir;
        w_step_mode = (r_state == c_ST_SHIFT) ? r_mode : bus.mode;
        w_out_bit   = w_step_dir ? r_q[0] : r_q[WIDTH-1];
        w_fill      = w_step_mode ? w_out_bit : bus.sin;
        if (w_step_dir) begin
            w_shifted = {w_fill, r_q[WIDTH-1:1]};
        end else begin
            w_shifted = {r_q[WIDTH-2:0], w_fill};
        end
        // start takes priority over shift_en in IDLE, so no step then
        w_do_step = !bus.load_en &&
                    ((r_state == c_ST_SHIFT) ||
                     ((r_state == c_ST_IDLE) && !bus.start && bus.shift_en));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_sout <= 1'b0;
        end else if (bus.load_en) begin
            r_q <= bus.d_load;
        end else if (w_do_step) begin
            r_q    <= w_shifted;
            r_sout <= w_out_bit;
        end
    end

    // ------------------------------------------------------------------
    // Burst counter and latched controls
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_dir  <= 1'b0;
            r_mode <= 1'b0;
        end else if (bus.load_en) begin
            r_cnt <= '0;
        end else if ((r_state == c_ST_IDLE) && bus.start) begin
            r_cnt  <= bus.count;
            r_dir  <= bus.dir;
            r_mode <= bus.mode;
        end else if (r_state == c_ST_SHIFT) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign bus.q    = r_q;
    assign bus.sout = r_sout;

endmodule
`default_nettype wire
